// File: rtl/window_sched_pkg.sv
// Shared encodings and sizing helpers for the window/FFT frame scheduler.
package window_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FRAME = 3'd2,
    ST_HOP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] WIND_RECT     = 2'b00;
  localparam logic [1:0] WIND_HAMMING  = 2'b01;
  localparam logic [1:0] WIND_BLACKMAN = 2'b10;
  localparam logic [1:0] WIND_KAISER   = 2'b11;

  function automatic int counter_width(input int np);
    return ($clog2(np) > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/sample_counter.sv
// Sample counter with runtime terminal value; wraps to zero on the terminal sample.
module sample_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en & (r_cnt == i_last);

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/window_frame_scheduler.sv
// Primes the window buffer, releases one frame per hop to the FFT, stops after P frames.
//   state | meaning
//   IDLE  | waiting for i_start
//   FILL  | priming NP samples into the window buffer
//   FRAME | frame presented to FFT, waiting for i_fft_ready
//   HOP   | collecting L new samples for the next frame
//   DONE  | one-cycle o_done, then IDLE
module window_frame_scheduler
  import window_sched_pkg::*;
#(
  parameter int NP      = 1024,
  parameter int L       = 256,
  parameter int P       = 64,
  parameter int NB_DROP = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [1:0]           i_WIND_sel,
  input  logic                 i_x_valid,
  input  logic                 i_fft_ready,
  output logic                 o_sample_en,
  output logic                 o_frame_valid,
  output logic [$clog2(P)-1:0] o_frame_idx,
  output logic [1:0]           o_WIND_sel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun,
  output logic [NB_DROP-1:0]   o_drop_cnt
);

  localparam int CW = counter_width(NP);
  localparam int FW = $clog2(P);
  localparam logic [CW-1:0] LAST_FILL  = CW'(NP - 1);
  localparam logic [CW-1:0] LAST_HOP   = CW'(L - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(P - 1);

  state_t              r_state;
  logic [FW-1:0]       r_frame_idx;
  logic [1:0]          r_wind_sel;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;
  logic [NB_DROP-1:0]  r_drop_cnt;

  logic          w_collect;
  logic          w_accept;
  logic          w_xfer;
  logic          w_drop;
  logic          w_start;
  logic          w_abort;
  logic          w_cnt_tc;
  logic [CW-1:0] w_cnt_last;

  assign w_collect  = (r_state == ST_FILL) || (r_state == ST_HOP);
  assign w_abort    = i_abort && (r_state != ST_IDLE);
  assign w_accept   = w_collect && i_x_valid && !i_abort;
  assign w_xfer     = (r_state == ST_FRAME) && i_fft_ready && !i_abort;
  assign w_drop     = ((r_state == ST_FRAME) || (r_state == ST_DONE)) && i_x_valid && !i_abort;
  assign w_start    = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_cnt_last = (r_state == ST_FILL) ? LAST_FILL : LAST_HOP;

  sample_counter #(.W(CW)) u_sample_counter (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (w_start || w_abort),
    .i_en    (w_accept),
    .i_last  (w_cnt_last),
    .o_tc    (w_cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_frame_idx <= '0;
      r_wind_sel  <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + NB_DROP'(1);
      end
      // Abort keeps overrun/drop count for software readout
      if (w_abort) begin
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
        r_frame_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state     <= ST_FILL;
              r_busy      <= 1'b1;
              r_wind_sel  <= i_WIND_sel;
              r_frame_idx <= '0;
              r_overrun   <= 1'b0;
              r_drop_cnt  <= '0;
            end
          end
          ST_FILL, ST_HOP: begin
            if (w_cnt_tc) r_state <= ST_FRAME;
          end
          ST_FRAME: begin
            if (w_xfer) begin
              if (r_frame_idx == LAST_FRAME) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_frame_idx <= r_frame_idx + FW'(1);
                r_state     <= ST_HOP;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sample_en   = w_accept;
  assign o_frame_valid = (r_state == ST_FRAME) && !i_abort;
  assign o_frame_idx   = r_frame_idx;
  assign o_WIND_sel    = r_wind_sel;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overrun     = r_overrun;
  assign o_drop_cnt    = r_drop_cnt;

endmodule
